decode_stage: RTL and testbench

//  Instruction-decode stage of the 16-bit pipeline, directly upstream of RegisterFile.

---
 rtl/decode_stage.sv | 194 +++++++++++++++++++
 tb/tb_decode_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Instruction-decode stage: field extraction, RF source select, scoreboard hazards, ID/EX register.
// Optional HLT stop: define DECODE_HALT_EN to make an accepted HLT freeze decode until reset.
module decode_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [DATA_W-1:0] if_instr,
    input  logic [DATA_W-1:0] if_pc,
    output logic              id_ready,
    output logic [REG_AW-1:0] rf_src1,
    output logic [REG_AW-1:0] rf_src2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_reg,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [3:0]        ex_opcode,
    output logic [REG_AW-1:0] ex_dst,
    output logic              ex_regwrite,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc,
    output logic              halted
);

    localparam int NREG = 1 << REG_AW;

    typedef struct packed {
        logic              valid;
        logic [3:0]        opcode;
        logic [REG_AW-1:0] dst;
        logic              regwrite;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
    } id_ex_t;

    id_ex_t ex_q, ex_d;
    logic [NREG-1:0] pending_q, pending_d;
    logic halted_q;

    logic [3:0]        op;
    logic [REG_AW-1:0] rd, rs, rt;
    logic              use1, use2, wr;
    logic [REG_AW-1:0] src1, src2;
    logic [DATA_W-1:0] imm;
    logic              use1_e, use2_e, wr_e;
    logic [NREG-1:0]   wb_clr, live;
    logic              hazard, accept;

    assign op = if_instr[15:12];
    assign rd = if_instr[11:8];
    assign rs = if_instr[7:4];
    assign rt = if_instr[3:0];

    always_comb begin
        use1 = 1'b0;
        use2 = 1'b0;
        src1 = '0;
        src2 = '0;
        wr   = 1'b0;
        imm  = '0;
        unique case (1'b1)
            (op[3] == 1'b0): begin
                use1 = 1'b1;
                src1 = rs;
                use2 = 1'b1;
                src2 = rt;
                wr   = 1'b1;
            end
            (op == 4'h8): begin
                use1 = 1'b1;
                src1 = rs;
                wr   = 1'b1;
                imm  = {{(DATA_W-5){if_instr[3]}}, if_instr[3:0], 1'b0};
            end
            (op == 4'h9): begin
                use1 = 1'b1;
                src1 = rs;
                use2 = 1'b1;
                src2 = rd;
                imm  = {{(DATA_W-5){if_instr[3]}}, if_instr[3:0], 1'b0};
            end
            (op == 4'hA || op == 4'hB): begin
                use1 = 1'b1;
                src1 = rd;
                wr   = 1'b1;
                imm  = {{(DATA_W-8){1'b0}}, if_instr[7:0]};
            end
            (op == 4'hC): begin
                imm = {{(DATA_W-10){if_instr[8]}}, if_instr[8:0], 1'b0};
            end
            (op == 4'hD): begin
                use1 = 1'b1;
                src1 = rs;
            end
            (op == 4'hE): begin
                wr = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // R0 is hardwired zero: never a hazard, never a write target
    assign use1_e  = use1 & (src1 != '0);
    assign use2_e  = use2 & (src2 != '0);
    assign wr_e    = wr & (rd != '0);
    assign rf_src1 = src1;
    assign rf_src2 = src2;

    always_comb begin
        wb_clr = '0;
        if (wb_valid) wb_clr[wb_reg] = 1'b1;
    end

    // a same-cycle writeback is forwarded by the RF, so it no longer blocks
    assign live   = pending_q & ~wb_clr;
    assign hazard = (use1_e & live[src1]) |
                    (use2_e & live[src2]) |
                    (wr_e & live[rd]);

    assign id_ready = ~halted_q & ~flush & ~hazard &
                      (~ex_q.valid | ex_ready);
    assign accept   = if_valid & id_ready;

    always_comb begin
        pending_d = pending_q & ~wb_clr;
        if (flush && ex_q.valid && ex_q.regwrite)
            pending_d[ex_q.dst] = 1'b0;
        if (accept && wr_e)
            pending_d[rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d.valid = 1'b0;
        end else if (accept) begin
            ex_d.valid    = 1'b1;
            ex_d.opcode   = op;
            ex_d.dst      = rd;
            ex_d.regwrite = wr_e;
            ex_d.op1      = use1_e ? rf_data1 : '0;
            ex_d.op2      = use2_e ? rf_data2 : '0;
            ex_d.imm      = imm;
            ex_d.pc       = if_pc;
        end else if (ex_ready) begin
            ex_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q      <= '0;
            pending_q <= '0;
        end else begin
            ex_q      <= ex_d;
            pending_q <= pending_d;
        end
    end

`ifdef DECODE_HALT_EN
    logic halted_d;

    assign halted_d = halted_q | (accept & (op == 4'hF));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) halted_q <= 1'b0;
        else      halted_q <= halted_d;
    end
`else
    assign halted_q = 1'b0;
`endif

    assign halted      = halted_q;
    assign ex_valid    = ex_q.valid;
    assign ex_opcode   = ex_q.opcode;
    assign ex_dst      = ex_q.dst;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_op1      = ex_q.op1;
    assign ex_op2      = ex_q.op2;
    assign ex_imm      = ex_q.imm;
    assign ex_pc       = ex_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode fields, hazards, stalls, flush, reset, HLT.
// RF model returns 0xA00n / 0xB00n for register n on ports 1 / 2.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        id_ready;
    logic [3:0]  rf_src1;
    logic [3:0]  rf_src2;
    logic [15:0] rf_data1;
    logic [15:0] rf_data2;
    logic        wb_valid;
    logic [3:0]  wb_reg;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [3:0]  ex_dst;
    logic        ex_regwrite;
    logic [15:0] ex_op1;
    logic [15:0] ex_op2;
    logic [15:0] ex_imm;
    logic [15:0] ex_pc;
    logic        halted;

    int n_chk;
    int n_pass;

    decode_stage dut (
        .clk         (clk),
        .rst         (rst),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_ready    (id_ready),
        .rf_src1     (rf_src1),
        .rf_src2     (rf_src2),
        .rf_data1    (rf_data1),
        .rf_data2    (rf_data2),
        .wb_valid    (wb_valid),
        .wb_reg      (wb_reg),
        .flush       (flush),
        .ex_ready    (ex_ready),
        .ex_valid    (ex_valid),
        .ex_opcode   (ex_opcode),
        .ex_dst      (ex_dst),
        .ex_regwrite (ex_regwrite),
        .ex_op1      (ex_op1),
        .ex_op2      (ex_op2),
        .ex_imm      (ex_imm),
        .ex_pc       (ex_pc),
        .halted      (halted)
    );

    assign rf_data1 = {12'hA00, rf_src1};
    assign rf_data2 = {12'hB00, rf_src2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        rst      = 1'b0;
        if_valid = 1'b0;
        if_instr = '0;
        if_pc    = '0;
        wb_valid = 1'b0;
        wb_reg   = '0;
        flush    = 1'b0;
        ex_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", ex_valid, 0);
        check("rst_dst", ex_dst, 0);
        check("rst_halt", halted, 0);
        rst = 1'b1;
        #1;
        check("rst_ready", id_ready, 1);

        // LW / LLB immediates and source selects
        if_valid = 1'b1;
        if_instr = 16'h856F;
        if_pc    = 16'h0010;
        #1;
        check("lw_src1", rf_src1, 6);
        check("lw_src2", rf_src2, 0);
        tick();
        check("lw_valid", ex_valid, 1);
        check("lw_imm", ex_imm, 16'hFFFE);
        check("lw_dst", ex_dst, 5);
        check("lw_op1", ex_op1, 16'hA006);
        check("lw_pc", ex_pc, 16'h0010);
        check("lw_wr", ex_regwrite, 1);
        if_instr = 16'hA3C4;
        if_pc    = 16'h0012;
        #1;
        check("llb_src1", rf_src1, 3);
        check("llb_ready", id_ready, 1);
        tick();
        check("llb_imm", ex_imm, 16'h00C4);
        check("llb_dst", ex_dst, 3);
        check("llb_op1", ex_op1, 16'hA003);
        if_valid = 1'b0;
        wb_valid = 1'b1;
        wb_reg   = 4'd5;
        tick();
        wb_reg = 4'd3;
        tick();
        wb_valid = 1'b0;
        check("bubble", ex_valid, 0);

        // RAW stall released by same-cycle writeback
        if_valid = 1'b1;
        if_instr = 16'h0312;
        if_pc    = 16'h0020;
        #1;
        tick();
        check("add_dst", ex_dst, 3);
        check("add_op2", ex_op2, 16'hB002);
        if_instr = 16'h1431;
        if_pc    = 16'h0022;
        #1;
        check("raw_stall", id_ready, 0);
        tick();
        check("raw_stall2", id_ready, 0);
        check("raw_bubble", ex_valid, 0);
        wb_valid = 1'b1;
        wb_reg   = 4'd3;
        #1;
        check("raw_wb_ready", id_ready, 1);
        tick();
        wb_valid = 1'b0;
        check("sub_valid", ex_valid, 1);
        check("sub_dst", ex_dst, 4);
        check("sub_op1", ex_op1, 16'hA003);
        check("sub_opc", ex_opcode, 1);

        // backpressure hold
        ex_ready = 1'b0;
        if_instr = 16'h2567;
        if_pc    = 16'h0024;
        #1;
        check("hold_ready", id_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_ex", {ex_valid, ex_dst, ex_op1}, {1'b1, 4'd4, 16'hA003});
            check("hold_ready_n", id_ready, 0);
        end
        ex_ready = 1'b1;
        #1;
        check("rel_ready", id_ready, 1);
        tick();
        check("and_dst", ex_dst, 5);
        check("and_ops", {ex_op1, ex_op2}, {16'hA006, 16'hB007});
        check("and_opc", ex_opcode, 2);
        if_valid = 1'b0;
        wb_valid = 1'b1;
        wb_reg   = 4'd4;
        tick();
        wb_reg = 4'd5;
        tick();
        wb_valid = 1'b0;

        // flush squashes EX and releases its scoreboard entry
        if_valid = 1'b1;
        if_instr = 16'h0312;
        if_pc    = 16'h0030;
        #1;
        tick();
        check("fl_pre", {ex_valid, ex_dst}, {1'b1, 4'd3});
        if_instr = 16'h1431;
        flush    = 1'b1;
        #1;
        check("fl_ready", id_ready, 0);
        tick();
        flush = 1'b0;
        check("fl_valid", ex_valid, 0);
        #1;
        check("fl_sub_ready", id_ready, 1);
        tick();
        check("fl_sub", {ex_valid, ex_dst}, {1'b1, 4'd4});
        if_valid = 1'b0;
        wb_valid = 1'b1;
        wb_reg   = 4'd4;
        tick();
        wb_valid = 1'b0;

        // R0 source and R0 destination
        if_valid = 1'b1;
        if_instr = 16'h0604;
        #1;
        tick();
        check("r0_op1", ex_op1, 0);
        check("r0_op2", ex_op2, 16'hB004);
        if_instr = 16'h0012;
        #1;
        tick();
        check("r0_wr", ex_regwrite, 0);

        // branch has no sources, so pending R6 does not stall it
        if_instr = 16'hC6FF;
        #1;
        check("br_ready", id_ready, 1);
        check("br_src", {rf_src1, rf_src2}, 0);
        tick();
        check("br_imm", ex_imm, 16'h01FE);
        if_instr = 16'hE600;
        #1;
        check("waw_ready", id_ready, 0);

        // asynchronous reset mid-stream
        rst = 1'b0;
        #1;
        check("mr_valid", ex_valid, 0);
        check("mr_imm", ex_imm, 0);
        tick();
        rst      = 1'b1;
        if_instr = 16'h0761;
        #1;
        check("mr_ready", id_ready, 1);
        tick();
        check("mr_dst", ex_dst, 7);

        // HLT
        if_instr = 16'hF000;
        #1;
        tick();
        check("hlt_opc", ex_opcode, 4'hF);
        check("hlt_wr", ex_regwrite, 0);
        if_instr = 16'h0312;
        #1;
`ifdef DECODE_HALT_EN
        check("hlt_halted", halted, 1);
        check("hlt_ready", id_ready, 0);
        tick();
        check("hlt_once", ex_valid, 0);
        check("hlt_sticky", {halted, id_ready}, 2'b10);
`else
        check("hlt_halted", halted, 0);
        check("hlt_ready", id_ready, 1);
        tick();
        check("hlt_next", ex_dst, 3);
`endif
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("hlt_rst", {halted, id_ready}, 2'b01);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
